// File: rtl/collision_scan_if.sv
// Bundle of scan request, snapshot inputs and published results for collision_scan.
// start is a request sampled only when the scanner is idle or done; done pulses once per scan.
interface collision_scan_if #(
    parameter int W = 10,
    parameter int N = 8
);
    localparam int CW = $clog2(N + 1);
    localparam int IW = $clog2(N);

    logic          start;
    logic [W-1:0]  ax;
    logic [W-1:0]  ay;
    logic [W-1:0]  ar;
    logic [N*W-1:0] tx;
    logic [N*W-1:0] ty;
    logic [N-1:0]  alive;
    logic          busy;
    logic          done;
    logic [N-1:0]  hit_mask;
    logic          hit_any;
    logic [CW-1:0] hit_count;
    logic [IW-1:0] first_idx;

    modport master (
        output start, ax, ay, ar, tx, ty, alive,
        input  busy, done, hit_mask, hit_any, hit_count, first_idx
    );

    modport slave (
        input  start, ax, ay, ar, tx, ty, alive,
        output busy, done, hit_mask, hit_any, hit_count, first_idx
    );
endinterface

// File: rtl/collision_scan.sv
// Player-vs-N-target box overlap scanner: one shared comparator, one target per clock.
// Define COLLISION_TOUCH_EN for inclusive compare (touching edges count as a hit).
module collision_scan #(
    parameter int W    = 10,
    parameter int N    = 8,
    parameter int HALF = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    collision_scan_if.slave  bus,
    output logic [1:0]       o_dbg_state
);
    localparam int CW = $clog2(N + 1);
    localparam int IW = $clog2(N);
    localparam int XW = W + 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_next_state;

    logic [W-1:0]   r_ax, r_ay, r_ar;
    logic [N*W-1:0] r_tx, r_ty;
    logic [N-1:0]   r_alive;
    logic [IW-1:0]  r_idx;

    logic [N-1:0]   r_work_mask;
    logic [CW-1:0]  r_work_cnt;
    logic [IW-1:0]  r_work_first;
    logic           r_found;

    logic [N-1:0]   r_hit_mask;
    logic           r_hit_any;
    logic [CW-1:0]  r_hit_count;
    logic [IW-1:0]  r_first_idx;

    logic           w_accept;
    logic           w_last;
    logic [W-1:0]   w_tx_k, w_ty_k;
    logic [XW-1:0]  w_dx, w_dy, w_lim;
    logic           w_in_x, w_in_y, w_hit;
    logic [N-1:0]   w_mask_nx;
    logic [CW-1:0]  w_cnt_nx;
    logic [IW-1:0]  w_first_nx;

    assign w_accept = bus.start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_last   = (r_idx == IW'(N - 1));

    // Compare in W+2 bits so box edges near 0 or 2^W-1 never wrap.
    assign w_tx_k = r_tx[r_idx*W +: W];
    assign w_ty_k = r_ty[r_idx*W +: W];
    assign w_dx   = (r_ax >= w_tx_k) ? (XW'(r_ax) - XW'(w_tx_k)) : (XW'(w_tx_k) - XW'(r_ax));
    assign w_dy   = (r_ay >= w_ty_k) ? (XW'(r_ay) - XW'(w_ty_k)) : (XW'(w_ty_k) - XW'(r_ay));
    assign w_lim  = XW'(r_ar) + XW'(HALF);

`ifdef COLLISION_TOUCH_EN
    assign w_in_x = (w_dx <= w_lim);
    assign w_in_y = (w_dy <= w_lim);
`else
    assign w_in_x = (w_dx < w_lim);
    assign w_in_y = (w_dy < w_lim);
`endif

    assign w_hit      = r_alive[r_idx] & w_in_x & w_in_y;
    assign w_mask_nx  = r_work_mask | (N'(w_hit) << r_idx);
    assign w_cnt_nx   = r_work_cnt + CW'(w_hit);
    assign w_first_nx = r_found ? r_work_first : (w_hit ? r_idx : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_next_state = S_SCAN;
            S_SCAN:  if (w_last)    w_next_state = S_DONE;
            S_DONE:  w_next_state = bus.start ? S_SCAN : S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ax         <= '0;
            r_ay         <= '0;
            r_ar         <= '0;
            r_tx         <= '0;
            r_ty         <= '0;
            r_alive      <= '0;
            r_idx        <= '0;
            r_work_mask  <= '0;
            r_work_cnt   <= '0;
            r_work_first <= '0;
            r_found      <= 1'b0;
            r_hit_mask   <= '0;
            r_hit_any    <= 1'b0;
            r_hit_count  <= '0;
            r_first_idx  <= '0;
        end else if (w_accept) begin
            r_ax         <= bus.ax;
            r_ay         <= bus.ay;
            r_ar         <= bus.ar;
            r_tx         <= bus.tx;
            r_ty         <= bus.ty;
            r_alive      <= bus.alive;
            r_idx        <= '0;
            r_work_mask  <= '0;
            r_work_cnt   <= '0;
            r_work_first <= '0;
            r_found      <= 1'b0;
        end else if (r_state == S_SCAN) begin
            r_work_mask  <= w_mask_nx;
            r_work_cnt   <= w_cnt_nx;
            r_work_first <= w_first_nx;
            r_found      <= r_found | w_hit;
            r_idx        <= r_idx + 1'b1;
            // Last target folds straight into the published results so all update together.
            if (w_last) begin
                r_hit_mask  <= w_mask_nx;
                r_hit_any   <= |w_mask_nx;
                r_hit_count <= w_cnt_nx;
                r_first_idx <= w_first_nx;
            end
        end
    end

    assign bus.busy      = (r_state == S_SCAN);
    assign bus.done      = (r_state == S_DONE);
    assign bus.hit_mask  = r_hit_mask;
    assign bus.hit_any   = r_hit_any;
    assign bus.hit_count = r_hit_count;
    assign bus.first_idx = r_first_idx;
    assign o_dbg_state   = r_state;
endmodule
